// File: rtl/ray_dispatcher.sv
// Raster ray issuer with a credit-limited in-flight window and framebuffer write-back.
// Optional frame duration counter is enabled by defining RAY_DISPATCH_CYCLE_COUNT_EN.
module ray_dispatcher #(
  parameter int WIDTH        = 1280,
  parameter int HEIGHT       = 720,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        ray_valid,
  output logic [10:0] pixel_h_out,
  output logic [9:0]  pixel_v_out,
  input  logic        ray_done,
  input  logic [71:0] pixel_color,
  input  logic [10:0] pixel_h_in,
  input  logic [9:0]  pixel_v_in,
  output logic        fb_we,
  output logic [19:0] fb_addr,
  output logic [71:0] fb_data,
  output logic        busy,
  output logic        frame_done,
  output logic [31:0] frame_cycles
);
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int IW    = $clog2(MAX_INFLIGHT + 1);
  localparam int CW    = $clog2(TOTAL + 1);

  localparam logic [IW-1:0] MAX_C     = IW'(MAX_INFLIGHT);
  localparam logic [CW-1:0] TOTAL_C   = CW'(TOTAL);
  localparam logic [10:0]   H_LAST    = 11'(WIDTH - 1);
  localparam logic [9:0]    V_LAST    = 10'(HEIGHT - 1);
  localparam logic [10:0]   H_LIM     = 11'(WIDTH);
  localparam logic [9:0]    V_LIM     = 10'(HEIGHT);
  localparam logic [19:0]   ROW_PITCH = 20'(WIDTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] completed_q, completed_d;
  logic [10:0]   h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic          ray_valid_q;
  logic          busy_q;
  logic          frame_done_q;
  logic          fb_we_q;
  logic [19:0]   fb_addr_q;
  logic [71:0]   fb_data_q;

  logic issue;
  logic accept;
  logic in_range;
  logic frame_done_d;

  // ray_valid_q is only ever set while in ISSUE with a free credit, so it is the issue event.
  assign issue    = ray_valid_q;
  assign accept   = ray_done && (inflight_q != '0);
  assign in_range = (pixel_h_in < H_LIM) && (pixel_v_in < V_LIM);

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    v_d         = v_q;
    inflight_d  = inflight_q + IW'(issue) - IW'(accept);
    completed_d = completed_q + CW'(accept);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = ISSUE;
          h_d         = '0;
          v_d         = '0;
          completed_d = '0;
        end
      end
      ISSUE: begin
        if (issue) begin
          if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
              state_d = DRAIN;
            end else begin
              v_d = v_q + 10'd1;
            end
          end else begin
            h_d = h_q + 11'd1;
          end
        end
      end
      DRAIN: begin
        if ((inflight_q == '0) && (completed_q == TOTAL_C)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered pulse lands in the same cycle the DRAIN->IDLE condition holds.
  assign frame_done_d = (state_d == DRAIN) && (inflight_d == '0) && (completed_d == TOTAL_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      inflight_q   <= '0;
      completed_q  <= '0;
      h_q          <= '0;
      v_q          <= '0;
      ray_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= inflight_d;
      completed_q  <= completed_d;
      h_q          <= h_d;
      v_q          <= v_d;
      ray_valid_q  <= (state_d == ISSUE) && (inflight_d < MAX_C);
      busy_q       <= (state_d != IDLE);
      frame_done_q <= frame_done_d;
      fb_we_q      <= accept && in_range;
      if (accept && in_range) begin
        fb_addr_q <= 20'(pixel_v_in) * ROW_PITCH + 20'(pixel_h_in);
        fb_data_q <= pixel_color;
      end
    end
  end

  assign ray_valid   = ray_valid_q;
  assign pixel_h_out = h_q;
  assign pixel_v_out = v_q;
  assign fb_we       = fb_we_q;
  assign fb_addr     = fb_addr_q;
  assign fb_data     = fb_data_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;

`ifdef RAY_DISPATCH_CYCLE_COUNT_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] frame_cycles_q;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == IDLE) begin
      if (state_d == ISSUE) begin
        cyc_d = '0;
      end
    end else if (cyc_q != '1) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  // Latching cyc_d counts the frame_done cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q          <= '0;
      frame_cycles_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      if (frame_done_q) begin
        frame_cycles_q <= cyc_d;
      end
    end
  end

  assign frame_cycles = frame_cycles_q;
`else
  assign frame_cycles = '0;
`endif

endmodule

// File: tb/tb_ray_dispatcher.sv
// Directed self-checking bench for ray_dispatcher at WIDTH=4, HEIGHT=2, MAX_INFLIGHT=2.
module tb_ray_dispatcher;
  localparam int W = 4;
  localparam int H = 2;
  localparam int M = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ray_done = 1'b0;
  logic [71:0] pixel_color = '0;
  logic [10:0] pixel_h_in = '0;
  logic [9:0]  pixel_v_in = '0;
  logic        ray_valid;
  logic [10:0] pixel_h_out;
  logic [9:0]  pixel_v_out;
  logic        fb_we;
  logic [19:0] fb_addr;
  logic [71:0] fb_data;
  logic        busy;
  logic        frame_done;
  logic [31:0] frame_cycles;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ray_dispatcher #(.WIDTH(W), .HEIGHT(H), .MAX_INFLIGHT(M)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ray_valid(ray_valid), .pixel_h_out(pixel_h_out), .pixel_v_out(pixel_v_out),
    .ray_done(ray_done), .pixel_color(pixel_color),
    .pixel_h_in(pixel_h_in), .pixel_v_in(pixel_v_in),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .frame_done(frame_done), .frame_cycles(frame_cycles)
  );

  function automatic logic [71:0] colour(input int h, input int v);
    return {8'hA5, 32'(h), 32'(v)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_done(input logic d, input int h, input int v);
    ray_done    = d;
    pixel_h_in  = 11'(h);
    pixel_v_in  = 10'(v);
    pixel_color = colour(h, v);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    drive_done(1'b0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    drive_done(1'b0, 0, 0);
    tick();
    tick();
    @(negedge clk);
    total++;
    if ({ray_valid, fb_we, busy, frame_done} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_strobes got=%b exp=0000", {ray_valid, fb_we, busy, frame_done});
    end
    total++;
    if (pixel_h_out !== 11'd0 || pixel_v_out !== 10'd0) begin
      bad++;
      $display("FAIL reset_pixel got=(%0d,%0d) exp=(0,0)", pixel_h_out, pixel_v_out);
    end
    total++;
    if (fb_addr !== 20'd0 || fb_data !== 72'd0) begin
      bad++;
      $display("FAIL reset_fb got addr=%0d data=%h exp=0", fb_addr, fb_data);
    end
    total++;
    if (frame_cycles !== 32'd0) begin
      bad++;
      $display("FAIL reset_frame_cycles got=%0d exp=0", frame_cycles);
    end
    tick();
    rst = 1'b0;
    $display("test_reset done");
  endtask

  // Latency-2 tracer over a whole frame; the completion for issue bad_idx reports column 5.
  task automatic run_frame(input int bad_idx, input string tag);
    int exp_h[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_v[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int due[8];
    int n_iss = 0;
    int n_wr = 0;
    int n_fd = 0;
    int fd_cyc = 0;
    int ret = 0;
    int first = -1;
    int wa;
    int exp_wr;
    do_reset();
    do_start();
    for (int k = 1; k <= 80; k++) begin
      if (ret < n_iss && due[ret] == k) begin
        drive_done(1'b1, (ret == bad_idx) ? 5 : exp_h[ret], exp_v[ret]);
        ret++;
      end else begin
        drive_done(1'b0, 0, 0);
      end
      @(negedge clk);
      if (ray_valid) begin
        if (first < 0) first = k;
        total++;
        if (n_iss >= 8) begin
          bad++;
          $display("FAIL %s extra_issue got=(%0d,%0d) exp=none", tag, pixel_h_out, pixel_v_out);
        end else begin
          if (pixel_h_out !== 11'(exp_h[n_iss]) || pixel_v_out !== 10'(exp_v[n_iss])) begin
            bad++;
            $display("FAIL %s issue%0d got=(%0d,%0d) exp=(%0d,%0d)", tag, n_iss,
                     pixel_h_out, pixel_v_out, exp_h[n_iss], exp_v[n_iss]);
          end
          $display("%s cycle %0d issue (%0d,%0d)", tag, k, pixel_h_out, pixel_v_out);
          due[n_iss] = k + 2;
          n_iss++;
        end
      end
      if (fb_we) begin
        wa = (bad_idx >= 0 && n_wr >= bad_idx) ? n_wr + 1 : n_wr;
        total++;
        if (fb_addr !== 20'(wa) || fb_data !== colour(wa % W, wa / W)) begin
          bad++;
          $display("FAIL %s write%0d got addr=%0d data=%h exp addr=%0d data=%h", tag, n_wr,
                   fb_addr, fb_data, wa, colour(wa % W, wa / W));
        end
        $display("%s cycle %0d write addr=%0d", tag, k, fb_addr);
        n_wr++;
      end
      if (frame_done) begin
        n_fd++;
        fd_cyc = k;
      end
      tick();
    end
    drive_done(1'b0, 0, 0);
    exp_wr = (bad_idx >= 0) ? 7 : 8;
    @(negedge clk);
    total++;
    if (first != 1) begin
      bad++;
      $display("FAIL %s first_issue_cycle got=%0d exp=1", tag, first);
    end
    total++;
    if (n_iss != 8) begin
      bad++;
      $display("FAIL %s issue_count got=%0d exp=8", tag, n_iss);
    end
    total++;
    if (n_wr != exp_wr) begin
      bad++;
      $display("FAIL %s write_count got=%0d exp=%0d", tag, n_wr, exp_wr);
    end
    total++;
    if (n_fd != 1) begin
      bad++;
      $display("FAIL %s frame_done_count got=%0d exp=1", tag, n_fd);
    end
    total++;
    if (busy !== 1'b0 || ray_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_after got busy=%b valid=%b exp=0,0", tag, busy, ray_valid);
    end
    total++;
`ifdef RAY_DISPATCH_CYCLE_COUNT_EN
    if (frame_cycles !== 32'(fd_cyc)) begin
      bad++;
      $display("FAIL %s frame_cycles got=%0d exp=%0d", tag, frame_cycles, fd_cyc);
    end
`else
    if (frame_cycles !== 32'd0) begin
      bad++;
      $display("FAIL %s frame_cycles got=%0d exp=0", tag, frame_cycles);
    end
`endif
    $display("%s frame_done at cycle %0d, frame_cycles=%0d", tag, fd_cyc, frame_cycles);
    tick();
  endtask

  task automatic test_full_frame();
    run_frame(-1, "full_frame");
  endtask

  task automatic test_out_of_range();
    run_frame(1, "out_of_range");
  endtask

  task automatic test_no_return();
    int cnt = 0;
    do_reset();
    do_start();
    for (int k = 1; k <= 20; k++) begin
      drive_done(1'b0, 0, 0);
      @(negedge clk);
      if (ray_valid) cnt++;
      tick();
    end
    @(negedge clk);
    total++;
    if (cnt != M) begin
      bad++;
      $display("FAIL no_return_issues got=%0d exp=%0d", cnt, M);
    end
    total++;
    if (ray_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL no_return_hold got valid=%b busy=%b exp=0,1", ray_valid, busy);
    end
    $display("no_return issued %0d rays, busy=%b", cnt, busy);
    tick();
  endtask

  // Window full at cycle 3; completions in cycles 3 and 4 (the latter coincides with an issue).
  task automatic test_same_cycle();
    logic ev[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int   eh[7] = '{0, 1, 0, 2, 3, 0, 0};
    logic dn[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int   dh[7] = '{0, 0, 0, 1, 0, 0, 0};
    logic ew[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int   ea[7] = '{0, 0, 0, 0, 1, 0, 0};
    do_reset();
    do_start();
    for (int k = 0; k < 7; k++) begin
      drive_done(dn[k], dh[k], 0);
      @(negedge clk);
      total++;
      if ({ray_valid, fb_we} !== {ev[k], ew[k]}) begin
        bad++;
        $display("FAIL same_cycle c%0d got valid=%b we=%b exp valid=%b we=%b",
                 k + 1, ray_valid, fb_we, ev[k], ew[k]);
      end
      if (ev[k]) begin
        total++;
        if (pixel_h_out !== 11'(eh[k]) || pixel_v_out !== 10'd0) begin
          bad++;
          $display("FAIL same_cycle_pixel c%0d got=(%0d,%0d) exp=(%0d,0)",
                   k + 1, pixel_h_out, pixel_v_out, eh[k]);
        end
      end
      if (ew[k]) begin
        total++;
        if (fb_addr !== 20'(ea[k])) begin
          bad++;
          $display("FAIL same_cycle_addr c%0d got=%0d exp=%0d", k + 1, fb_addr, ea[k]);
        end
      end
      $display("same_cycle c%0d valid=%b h=%0d we=%b", k + 1, ray_valid, pixel_h_out, fb_we);
      tick();
    end
    drive_done(1'b0, 0, 0);
  endtask

  task automatic test_reset_midframe();
    do_reset();
    do_start();
    tick();
    tick();
    drive_done(1'b1, 0, 0);
    tick();
    drive_done(1'b0, 0, 0);
    @(negedge clk);
    total++;
    if (ray_valid !== 1'b1 || pixel_h_out !== 11'd2) begin
      bad++;
      $display("FAIL midframe_third_issue got valid=%b h=%0d exp 1,2", ray_valid, pixel_h_out);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_done(1'b1, 1, 0);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || ray_valid !== 1'b0 || pixel_h_out !== 11'd0) begin
      bad++;
      $display("FAIL midframe_after_rst got busy=%b valid=%b h=%0d exp 0,0,0",
               busy, ray_valid, pixel_h_out);
    end
    tick();
    drive_done(1'b1, 2, 0);
    @(negedge clk);
    total++;
    if (fb_we !== 1'b0) begin
      bad++;
      $display("FAIL stale_done1 got we=%b exp=0", fb_we);
    end
    tick();
    drive_done(1'b0, 0, 0);
    start = 1'b1;
    @(negedge clk);
    total++;
    if (fb_we !== 1'b0) begin
      bad++;
      $display("FAIL stale_done2 got we=%b exp=0", fb_we);
    end
    tick();
    start = 1'b0;
    @(negedge clk);
    total++;
    if (ray_valid !== 1'b1 || pixel_h_out !== 11'd0 || pixel_v_out !== 10'd0) begin
      bad++;
      $display("FAIL restart_first got valid=%b (%0d,%0d) exp 1 (0,0)",
               ray_valid, pixel_h_out, pixel_v_out);
    end
    $display("reset_midframe restart valid=%b (%0d,%0d)", ray_valid, pixel_h_out, pixel_v_out);
    tick();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_out_of_range();
    test_no_return();
    test_same_cycle();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ray_dispatcher.md
RAY_DISPATCHER -- requirements
Module: ray_dispatcher

Interface
REQ-001 SHALL have parameter WIDTH, default 1280, horizontal pixel count.
REQ-002 SHALL have parameter HEIGHT, default 720, vertical pixel count.
REQ-003 SHALL have parameter MAX_INFLIGHT, default 4, maximum rays issued and not yet completed.
REQ-004 SHALL have ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  frame start pulse.
- ray_valid  out  1  ray issue strobe to tracer.
- pixel_h_out  out  11  issued pixel column.
- pixel_v_out  out  10  issued pixel row.
- ray_done  in  1  tracer completion strobe.
- pixel_color  in  fp24_vec3 (72)  completed colour.
- pixel_h_in  in  11  completed column.
- pixel_v_in  in  10  completed row.
- fb_we  out  1  framebuffer write enable.
- fb_addr  out  20  framebuffer address.
- fb_data  out  72  framebuffer data, raw fp24_vec3.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle end-of-frame pulse.
- frame_cycles  out  32  frame duration (macro-gated, REQ-022).

Function
REQ-005 SHALL implement states IDLE, ISSUE, DRAIN.
REQ-006 IDLE: start=1 -> ISSUE, h=0, v=0, completed count=0; otherwise hold.
REQ-007 ISSUE: ray_valid=1 for the current (h,v) in any cycle where in-flight count < MAX_INFLIGHT, else 0.
REQ-008 Issue order: raster; h increments per issue; at h=WIDTH-1, h wraps to 0 and v increments.
REQ-009 Issuing (WIDTH-1, HEIGHT-1) SHALL move ISSUE -> DRAIN.
REQ-010 DRAIN -> IDLE when in-flight count=0 and completed count=WIDTH*HEIGHT; frame_done=1 in that transition cycle.
REQ-011 First ray_valid SHALL occur the cycle after start is sampled.
REQ-012 In-flight count: +1 on issue, -1 on ray_done, unchanged when both occur in the same cycle.
REQ-013 ray_done when in-flight count=0 SHALL be ignored: no decrement, no write.
REQ-014 Accepted ray_done at cycle t -> fb_we=1 at t+1, fb_addr=pixel_v_in*WIDTH+pixel_h_in, fb_data=pixel_color, all registered.
REQ-015 Accepted ray_done with pixel_h_in>=WIDTH or pixel_v_in>=HEIGHT SHALL return a credit and count as completed, with fb_we=0.
REQ-016 Completions SHALL be accepted in any state, including IDLE if count>0; out-of-order coordinates allowed.
REQ-017 start while not IDLE SHALL be ignored.
REQ-018 busy=1 in ISSUE and DRAIN, 0 in IDLE.
REQ-019 Counter widths SHALL fit MAX_INFLIGHT and WIDTH*HEIGHT with no overflow.

Reset
REQ-020 rst SHALL force IDLE; in-flight and completed counts=0; h=v=0; outputs ray_valid, fb_we, busy, frame_done=0; pixel_h_out, pixel_v_out, fb_addr, fb_data=0.
REQ-021 rst mid-frame SHALL abandon the frame; stale ray_done after reset falls under REQ-013.

Configuration
REQ-022 Macro RAY_DISPATCH_CYCLE_COUNT_EN defined: 32-bit counter clears on leaving IDLE, increments each cycle while busy, saturates at all-ones; its value is latched into frame_cycles on frame_done and held until the next frame_done; reset value 0.
REQ-023 Macro undefined: frame_cycles tied to 0, no counter logic.

Verification (WIDTH=4, HEIGHT=2, MAX_INFLIGHT=2 unless stated)
REQ-024 Tracer returns each ray after 2 cycles -> 8 issues in raster order (0,0)..(3,1); 8 writes to addresses 0..7; one frame_done; busy low after.
REQ-025 Tracer never returns -> exactly 2 ray_valid pulses, then ray_valid held 0 and busy held 1.
REQ-026 ray_done on the same cycle as an issue while count=2 -> count stays 2, no third outstanding ray.
REQ-027 Completion (h=5,v=0) -> fb_we stays 0, credit returned, frame still completes after remaining completions.
REQ-028 rst after 3 issues, then 2 stale ray_done pulses -> no fb_we; new start issues (0,0) first.
REQ-029 With RAY_DISPATCH_CYCLE_COUNT_EN defined, latency-2 tracer -> frame_cycles equals the cycle count from leaving IDLE to frame_done; without the macro, frame_cycles=0.
